// File: rtl/req_encoder4_2.sv
// Round-robin request encoder: sticky pending set of one-hot request events,
// served one index at a time on a valid/ready channel.
module req_encoder4_2 #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] req,
  output logic [W-1:0] out_code,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] pending,
  output logic         overrun
);

  // First set bit of c, scanning upward from p with wrap modulo N.
  function automatic logic [W-1:0] rr_pick(input logic [N-1:0] c, input logic [W-1:0] p);
    logic [W-1:0] pick;
    logic [W-1:0] j;
    logic         found;
    int           jj;
    pick  = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      jj = (int'(p) + k) % N;
      j  = W'(jj);
      if (!found && c[j]) begin
        pick  = j;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  logic [W-1:0] ptr_p1;
  logic [N-1:0] ereq_p0;
  logic [N-1:0] cand_p0;
  logic [N-1:0] selmask_p0;
  logic [W-1:0] sel_p0;
  logic         load_p0;

  // Stage p0: candidate set includes this cycle's events so a lone request bypasses pending.
  always_comb begin
    ereq_p0    = req & {N{en}};
    cand_p0    = pending | ereq_p0;
    load_p0    = (!out_valid || out_ready) && (cand_p0 != '0);
    sel_p0     = rr_pick(cand_p0, ptr_p1);
    selmask_p0 = load_p0 ? (N'(1) << sel_p0) : '0;
  end

  // Stage p1: registered offer, pending set and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_code  <= '0;
      ptr_p1    <= '0;
      overrun   <= 1'b0;
    end else begin
      pending <= cand_p0 & ~selmask_p0;
      overrun <= |(ereq_p0 & pending & ~selmask_p0);
      if (load_p0) begin
        out_code  <= sel_p0;
        out_valid <= 1'b1;
        ptr_p1    <= (sel_p0 == W'(N - 1)) ? '0 : sel_p0 + W'(1);
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_req_encoder4_2.sv
// Bench for req_encoder4_2: per-cycle comparison against a behavioural model
// plus directed checks with hand-computed expectations.
module tb_req_encoder4_2;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic [1:0] out_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] pending;
  logic       overrun;

  int checks = 0;
  int fails  = 0;
  bit chk_on = 1'b0;

  req_encoder4_2 #(.N(4), .W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .req      (req),
    .out_code (out_code),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pending  (pending),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pending bits as a plain array, index chosen by a wrapping scan.
  bit m_pend[4];
  int m_ptr, m_code, m_sel;
  bit m_valid, m_over;
  bit m_ev[4];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) m_pend[i] = 1'b0;
      m_ptr = 0; m_code = 0; m_valid = 1'b0; m_over = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) m_ev[i] = en && req[i];
      m_sel = -1;
      if (!m_valid || out_ready)
        for (int k = 0; k < 4; k++)
          if (m_sel < 0 && (m_pend[(m_ptr + k) % 4] || m_ev[(m_ptr + k) % 4]))
            m_sel = (m_ptr + k) % 4;
      m_over = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (m_ev[i] && m_pend[i] && i != m_sel) m_over = 1'b1;
        m_pend[i] = (m_pend[i] || m_ev[i]) && i != m_sel;
      end
      if (m_sel >= 0) begin
        m_code = m_sel; m_valid = 1'b1; m_ptr = (m_sel + 1) % 4;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  function automatic int m_pend_vec();
    int v = 0;
    for (int i = 0; i < 4; i++) if (m_pend[i]) v += (1 << i);
    return v;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model out_valid", int'(out_valid), int'(m_valid));
      chk("model pending", int'(pending), m_pend_vec());
      chk("model overrun", int'(overrun), int'(m_over));
      if (m_valid) chk("model out_code", int'(out_code), m_code);
    end
  end

  task automatic step(input logic [3:0] r, input logic e, input logic rdy);
    req = r; en = e; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; req = '0; en = 1'b1; out_ready = 1'b1;
    // Reset held two cycles with all requests active.
    step(4'b1111, 1'b1, 1'b1);
    chk_on = 1'b1;
    step(4'b1111, 1'b1, 1'b1);
    chk("rst out_valid", int'(out_valid), 0);
    chk("rst pending", int'(pending), 0);
    chk("rst overrun", int'(overrun), 0);
    reset = 1'b1;
    step(4'b0000, 1'b1, 1'b1);
    chk("idle out_valid", int'(out_valid), 0);

    // 1011 from ptr=0: codes 0,1,3 back to back.
    step(4'b1011, 1'b1, 1'b1);
    chk("multi code0", int'(out_code), 0);
    chk("multi valid0", int'(out_valid), 1);
    chk("multi pend0", int'(pending), 4'b1010);
    step(4'b0000, 1'b1, 1'b1);
    chk("multi code1", int'(out_code), 1);
    step(4'b0000, 1'b1, 1'b1);
    chk("multi code3", int'(out_code), 3);
    chk("multi valid3", int'(out_valid), 1);
    step(4'b0000, 1'b1, 1'b1);
    chk("multi drained", int'(out_valid), 0);

    // Single pulse on source 2.
    step(4'b0100, 1'b1, 1'b1);
    chk("single valid", int'(out_valid), 1);
    chk("single code", int'(out_code), 2);
    chk("single pend", int'(pending), 0);
    step(4'b0000, 1'b1, 1'b1);
    chk("single drop", int'(out_valid), 0);

    // Serve index 1 (ptr becomes 2), then 0011 must go 0 then 1.
    step(4'b0010, 1'b1, 1'b1);
    chk("rr serve1", int'(out_code), 1);
    step(4'b0000, 1'b1, 1'b1);
    step(4'b0011, 1'b1, 1'b1);
    chk("rr first", int'(out_code), 0);
    step(4'b0000, 1'b1, 1'b1);
    chk("rr second", int'(out_code), 1);
    step(4'b0000, 1'b1, 1'b1);
    chk("rr drained", int'(out_valid), 0);

    // Backpressure: offer held stable, second event pends, third overruns.
    step(4'b0001, 1'b1, 1'b0);
    for (int c = 0; c < 5; c++) begin
      chk("bp hold valid", int'(out_valid), 1);
      chk("bp hold code", int'(out_code), 0);
      if (c < 4) step(4'b0000, 1'b1, 1'b0);
    end
    step(4'b0001, 1'b1, 1'b0);
    chk("bp pend", int'(pending), 4'b0001);
    chk("bp no overrun", int'(overrun), 0);
    step(4'b0001, 1'b1, 1'b0);
    chk("bp overrun", int'(overrun), 1);
    chk("bp pend kept", int'(pending), 4'b0001);
    step(4'b0000, 1'b1, 1'b0);
    chk("bp overrun pulse", int'(overrun), 0);
    step(4'b0000, 1'b1, 1'b1);
    chk("bp 2nd delivery valid", int'(out_valid), 1);
    chk("bp 2nd delivery code", int'(out_code), 0);
    chk("bp 2nd pend", int'(pending), 0);
    step(4'b0000, 1'b1, 1'b1);
    chk("bp drained", int'(out_valid), 0);

    // en=0 blocks new events.
    for (int c = 0; c < 3; c++) begin
      step(4'b1111, 1'b0, 1'b1);
      chk("en0 pend", int'(pending), 0);
      chk("en0 valid", int'(out_valid), 0);
      chk("en0 overrun", int'(overrun), 0);
    end

    // Pending bit 3 still drains with en=0.
    step(4'b0010, 1'b1, 1'b0);
    chk("drain busy code", int'(out_code), 1);
    step(4'b1000, 1'b1, 1'b0);
    chk("drain pend", int'(pending), 4'b1000);
    step(4'b1111, 1'b0, 1'b1);
    chk("drain code", int'(out_code), 3);
    chk("drain valid", int'(out_valid), 1);
    chk("drain pend0", int'(pending), 0);
    chk("drain overrun", int'(overrun), 0);
    step(4'b0000, 1'b0, 1'b1);
    chk("drain done", int'(out_valid), 0);

    // Reset mid-operation discards offer and pending without handshake.
    step(4'b0101, 1'b1, 1'b0);
    chk("mid offer", int'(out_code), 0);
    chk("mid pend", int'(pending), 4'b0100);
    reset = 1'b0;
    step(4'b0101, 1'b1, 1'b0);
    chk("mid rst valid", int'(out_valid), 0);
    chk("mid rst pend", int'(pending), 0);
    chk("mid rst code", int'(out_code), 0);
    reset = 1'b1;
    step(4'b0000, 1'b1, 1'b1);
    chk("mid after valid", int'(out_valid), 0);
    step(4'b0000, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/req_encoder4_2.md
Name: req_encoder4_2

Overview:
- Registered, round-robin 4-to-2 request encoder. The sequential counterpart of the team's 2-to-4 decoder: it turns one-hot request events back into a 2-bit index.
- Request pulses from up to N sources are latched into a sticky pending set.
- Pending requests are served one at a time, each as an encoded index on a valid/ready output channel.
- Sits between event sources (interrupt or completion strobes) and a consumer that handles one index per transfer.

Parameters:
N, 4, number of request lines
W, 2, code width; must equal $clog2(N)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
en  input  1  request enable; when 0, new req bits are ignored
req  input  N  request events; bit i high in a cycle = one event for source i
out_code  output  W  encoded index of the request being offered
out_valid  output  1  out_code holds a valid index
out_ready  input  1  consumer accepts out_code when out_valid and out_ready are both 1
pending  output  N  registered pending-request set (not yet loaded to output)
overrun  output  1  one-cycle pulse: a request hit a source whose pending bit was already set

Behaviour:
- Reset (reset==0 at a clk edge):
  - pending=0, out_valid=0, out_code=0, rr pointer=0, overrun=0.
  - reset dominates every other input that cycle.
- Effective request: ereq = req & {N{en}}.
- Candidate set: cand = pending | ereq. This is the bypass path, so a lone request is offered with no pending-stage delay.
- Load condition: load = (!out_valid || out_ready) && (cand != 0).
- On load:
  - Select the first set bit of cand, scanning from index ptr upward with wrap mod N.
  - out_code <= index; out_valid <= 1; ptr <= (index+1) mod N.
  - The selected bit is not left set in pending.
- When out_valid && out_ready && cand==0: out_valid <= 0, out_code holds its last value.
- While out_valid && !out_ready: out_code and out_valid are held stable, and no load occurs.
- Pending update, for bit i:
  - pending[i] <= (pending[i] | ereq[i]) & ~(load && sel==i).
  - If ereq[i] and i is the bit selected that cycle, the event is consumed by the load and is not re-pended.
  - A source holding req high for k cycles generates k events.
- Overrun:
  - overrun <= |(ereq & pending & ~selmask), where selmask is the one-hot of the selected bit (0 if no load).
  - The duplicate event is merged (dropped); no counter is kept.
- Latency: req at edge t with the output idle gives out_valid=1 and out_code=i after edge t.
- Throughput: one index per cycle while out_ready stays 1.
- en=0:
  - Existing pending bits still drain normally; only new events are blocked.
  - overrun is not raised for blocked events.
- Fairness: after index i is served, i has the lowest priority. Any continuously pending source is served within N loads.
- Reset mid-operation: an offered code and all pending bits are discarded with no handshake.

Test Plan:
- Reset held low 2 cycles with req=4'b1111, en=1 -> out_valid=0, pending=0, overrun=0. Release, req=0 -> out_valid stays 0.
- en=1, out_ready=1, single pulse req=4'b0100 -> next cycle out_valid=1, out_code=2, pending=0. Following cycle out_valid=0.
- out_ready=1, pulse req=4'b1011 from ptr=0 -> codes 0,1,3 on three consecutive cycles, then out_valid=0.
- Round-robin: serve index 1. Then pulse req=4'b0011 with ptr=2 -> order 0 then 1, since scan goes 2,3,0,1.
- Backpressure, out_ready=0:
  - Pulse req=4'b0001 -> out_code=0 held 5 cycles.
  - Pulse req=4'b0001 again -> pending=4'b0001, no overrun.
  - Third pulse req=4'b0001 -> overrun=1 for exactly one cycle.
  - Raise out_ready -> code 0 delivered twice total.
- en=0, req=4'b1111 for 3 cycles -> pending unchanged, out_valid=0. Then with pending=4'b1000, en=0, out_ready=1 -> code 3 still delivered.
